module_uart_tx: RTL and testbench

//  Serial UART transmitter draining the peripheral TX FIFO (module_fifo read side).

---
 rtl/module_uart_tx.sv | 133 +++++++++++++
 tb/tb_module_uart_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/module_uart_tx.sv
// UART transmitter: pops bytes from a first-word-fall-through FIFO and
// serialises them LSB first as start / DATA_BITS data / STOP_BITS stop frames.
module module_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_re,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;

  logic bit_end;
  logic last_stop;
  logic accept;

  // Bit-period end, final stop cycle and the accept/pop decision.
  // fifo_re is held low while reset is asserted so the FIFO never pops a
  // byte the transmitter is not going to latch.
  always_comb begin
    bit_end   = 1'b0;
    last_stop = 1'b0;
    accept    = 1'b0;
    bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    last_stop = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
    accept    = reset && enable && !fifo_empty && ((state == IDLE) || last_stop);
    fifo_re   = accept;
  end

  // Frame sequencer with registered tx and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (accept) begin
            shift <= fifo_dout;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              state    <= STOP;
              tx       <= 1'b1;
            end else begin
              // tx takes the next bit directly so it changes on the same edge
              // the shift register advances.
              bit_idx <= bit_idx + BW'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (last_stop) begin
              if (accept) begin
                shift <= fifo_dout;
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                tx    <= 1'b1;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_uart_tx.sv
// Directed bench for module_uart_tx: 8N1 and 7N2 instances at 4 clocks/bit,
// each fed from a small FIFO model held in the bench.
module tb_module_uart_tx;

  localparam int N  = 4;
  localparam int FL = 10 * N;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable, fifo_empty, fifo_re, tx, busy;
  logic [7:0] fifo_dout;
  logic       enable2, fifo_empty2, fifo_re2, tx2, busy2;
  logic [6:0] fifo_dout2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int vecs = 0;
  int errs = 0;
  int last_wait = 0;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t vt[5];

  always #5 clk = ~clk;

  module_uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_re(fifo_re), .tx(tx), .busy(busy)
  );

  module_uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_dout(fifo_dout2), .fifo_re(fifo_re2), .tx(tx2), .busy(busy2)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty  = (q1.size() == 0);
    fifo_dout   = fifo_empty ? 8'h00 : q1[0];
    fifo_empty2 = (q2.size() == 0);
    fifo_dout2  = fifo_empty2 ? 7'h00 : q2[0][6:0];
  endtask

  task automatic push(input logic sel, input logic [7:0] d);
    if (sel) q2.push_back(d);
    else     q1.push_back(d);
    refresh();
    #1;
  endtask

  // One clock: the pop decision is the fifo_re seen at the negedge, applied
  // just after the rising edge; returns aligned on the next negedge.
  task automatic step();
    logic r1, r2;
    r1 = fifo_re;
    r2 = fifo_re2;
    @(posedge clk);
    #1;
    if (r1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
    if (r2 === 1'b1 && q2.size() > 0) void'(q2.pop_front());
    refresh();
    @(negedge clk);
  endtask

  task automatic idle_check(input logic sel, input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if ((sel ? tx2 : tx) !== 1'b1 || (sel ? busy2 : busy) !== 1'b0 ||
          (sel ? fifo_re2 : fifo_re) !== 1'b0) bad++;
      step();
    end
    check({tag, "_idle_bad_cycles"}, bad, 0);
  endtask

  // Waits (bounded) for the accept cycle, then checks every cycle of the
  // 10-bit-period frame. Returns on the negedge of the final stop cycle.
  task automatic run_frame(input logic sel, input logic [9:0] exp,
                           input logic exp_last_re, input int drop_at,
                           input string tag);
    int w;
    int bad_ctl;
    w = 0;
    while (((sel ? fifo_re2 : fifo_re) !== 1'b1) && w < 200) begin
      step();
      w++;
    end
    last_wait = w;
    check({tag, "_accept"}, {31'd0, (sel ? fifo_re2 : fifo_re)}, 32'd1);
    if (w >= 200) return;
    step();
    bad_ctl = 0;
    for (int b = 0; b < 10; b++) begin
      logic [N-1:0] tv;
      tv = '0;
      for (int c = 0; c < N; c++) begin
        int   idx;
        logic er;
        idx   = b * N + c;
        tv[c] = sel ? tx2 : tx;
        er    = (idx == FL - 1) ? exp_last_re : 1'b0;
        if ((sel ? busy2 : busy) !== 1'b1 || (sel ? fifo_re2 : fifo_re) !== er) bad_ctl++;
        if (idx == drop_at) enable = 1'b0;
        if (idx != FL - 1) step();
      end
      check($sformatf("%s_bit%0d_tx", tag, b), {28'd0, tv}, {28'd0, {N{exp[b]}}});
    end
    check({tag, "_busy_re_bad_cycles"}, bad_ctl, 0);
  endtask

  initial begin
    enable  = 1'b1;
    enable2 = 1'b1;
    refresh();

    vt[0] = '{1'b0, 8'hA5, 10'b1101001010, "a5"};
    vt[1] = '{1'b0, 8'h0F, 10'b1000011110, "0f"};
    vt[2] = '{1'b0, 8'hC3, 10'b1110000110, "c3"};
    vt[3] = '{1'b1, 8'hFF, 10'b1111111110, "db7_ff"};
    vt[4] = '{1'b1, 8'h80, 10'b1100000000, "db7_80"};

    // Reset and idle with an empty FIFO.
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_tx2", {31'd0, tx2}, 32'd1);
    step();
    step();
    reset = 1'b1;
    #1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_re !== 1'b0 ||
            tx2 !== 1'b1 || busy2 !== 1'b0 || fifo_re2 !== 1'b0) bad++;
        step();
      end
      check("idle_100_bad_cycles", bad, 0);
    end

    // Single frames from the table.
    for (int v = 0; v < 5; v++) begin
      push(vt[v].sel, vt[v].data);
      run_frame(vt[v].sel, vt[v].exp, 1'b0, -1, vt[v].name);
      step();
      idle_check(vt[v].sel, 8, vt[v].name);
    end

    // Back-to-back frames with no idle gap.
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    run_frame(1'b0, 10'b1000000000, 1'b1, -1, "b2b_00");
    run_frame(1'b0, 10'b1111111110, 1'b0, -1, "b2b_ff");
    check("b2b_gap_cycles", last_wait, 0);
    step();
    idle_check(1'b0, 8, "b2b");

    // enable dropped during data bit 3 of the first frame.
    push(1'b0, 8'h3C);
    push(1'b0, 8'h55);
    run_frame(1'b0, 10'b1001111000, 1'b0, 17, "en_3c");
    step();
    idle_check(1'b0, 20, "en_hold");
    check("en_hold_fifo_level", q1.size(), 1);
    enable = 1'b1;
    #1;
    run_frame(1'b0, 10'b1010101010, 1'b0, -1, "en_55");
    check("en_gap_cycles", last_wait, 0);
    step();
    idle_check(1'b0, 8, "en_55");

    // Reset during data bit 2 of 0x81; 0x42 follows after release.
    push(1'b0, 8'h81);
    push(1'b0, 8'h42);
    begin
      int w;
      w = 0;
      while (fifo_re !== 1'b1 && w < 200) begin
        step();
        w++;
      end
      check("rst_accept", {31'd0, fifo_re}, 32'd1);
    end
    step();
    for (int i = 0; i < 12; i++) step();
    check("rst_pre_tx", {31'd0, tx}, 32'd0);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx}, 32'd1);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_re_gated", {31'd0, fifo_re}, 32'd0);
    step();
    step();
    check("rst_fifo_level", q1.size(), 1);
    reset = 1'b1;
    #1;
    run_frame(1'b0, 10'b1010000100, 1'b0, -1, "rst_42");
    step();
    idle_check(1'b0, 8, "rst_42");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
